// File: rtl/wb_arbiter_2m.sv
// ----------------------------------------------------------------------------
// wb_arbiter_2m
// Two-master Wishbone arbiter in front of a single shared slave (CSR memory).
// Both masters compete for the slave. A tie is broken round-robin using
// last_grant. A grant is held for as long as the owning master keeps CYC
// asserted. A stalled slave is cut off after TIMEOUT unacknowledged strobe
// cycles, and the owning master then sees a single-cycle ERR.
//
// Parameters
//   DATA_SIZE : width of every data bus
//   ADR_SIZE  : width of every address bus
//   TIMEOUT   : granted strobe cycles without S_ACK_I before ERR (2..255)
//
// Ports
//   CLK_I, RST_I        : clock; asynchronous active-low reset
//   Mn_CYC_I/STB_I/WE_I : Wishbone control from master n (n = 0,1)
//   Mn_ADR_I, Mn_DAT_I  : address and write data from master n
//   Mn_DAT_O            : read data to master n (0 unless granted)
//   Mn_ACK_O, Mn_ERR_O  : acknowledge / timeout error to master n
//   S_CYC_O..S_DAT_O    : request forwarded to the shared slave
//   S_DAT_I, S_ACK_I    : read data and acknowledge from the slave
// ----------------------------------------------------------------------------
module wb_arbiter_2m #(
    parameter int DATA_SIZE = 64,
    parameter int ADR_SIZE  = 3,
    parameter int TIMEOUT   = 16
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,

    input  logic                 M0_CYC_I,
    input  logic                 M0_STB_I,
    input  logic                 M0_WE_I,
    input  logic [ADR_SIZE-1:0]  M0_ADR_I,
    input  logic [DATA_SIZE-1:0] M0_DAT_I,
    output logic [DATA_SIZE-1:0] M0_DAT_O,
    output logic                 M0_ACK_O,
    output logic                 M0_ERR_O,

    input  logic                 M1_CYC_I,
    input  logic                 M1_STB_I,
    input  logic                 M1_WE_I,
    input  logic [ADR_SIZE-1:0]  M1_ADR_I,
    input  logic [DATA_SIZE-1:0] M1_DAT_I,
    output logic [DATA_SIZE-1:0] M1_DAT_O,
    output logic                 M1_ACK_O,
    output logic                 M1_ERR_O,

    output logic                 S_CYC_O,
    output logic                 S_STB_O,
    output logic                 S_WE_O,
    output logic [ADR_SIZE-1:0]  S_ADR_O,
    output logic [DATA_SIZE-1:0] S_DAT_O,
    input  logic [DATA_SIZE-1:0] S_DAT_I,
    input  logic                 S_ACK_I
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_last_grant;
    logic [CW-1:0]  r_cnt;

    logic           w_req0;
    logic           w_req1;
    logic           w_g0;
    logic           w_g1;
    logic           w_cyc_sel;
    logic           w_stb_sel;
    logic           w_timeout;

    assign w_req0 = M0_CYC_I & M0_STB_I;
    assign w_req1 = M1_CYC_I & M1_STB_I;
    assign w_g0   = (r_state == GRANT0);
    assign w_g1   = (r_state == GRANT1);

    // Control of whichever master currently owns the slave (0 in IDLE).
    assign w_cyc_sel = (w_g0 & M0_CYC_I) | (w_g1 & M1_CYC_I);
    assign w_stb_sel = (w_g0 & M0_STB_I) | (w_g1 & M1_STB_I);

    // Fires on the TIMEOUT-th consecutive unacknowledged strobe cycle.
    // Gating with ~S_ACK_I lets a late ACK win the race against the timeout.
    assign w_timeout = (w_g0 | w_g1) & (r_cnt == CNT_LAST) & w_stb_sel & ~S_ACK_I;

    // The slave request is a pure mux on the grant, so the bus follows the
    // owning master with no extra latency and drops in the cycle CYC drops.
    assign S_CYC_O = w_cyc_sel;
    assign S_STB_O = w_stb_sel;
    assign S_WE_O  = (w_g0 & M0_WE_I) | (w_g1 & M1_WE_I);
    assign S_ADR_O = w_g0 ? M0_ADR_I : (w_g1 ? M1_ADR_I : '0);
    assign S_DAT_O = w_g0 ? M0_DAT_I : (w_g1 ? M1_DAT_I : '0);

    assign M0_DAT_O = w_g0 ? S_DAT_I : '0;
    assign M1_DAT_O = w_g1 ? S_DAT_I : '0;
    assign M0_ACK_O = w_g0 & S_ACK_I;
    assign M1_ACK_O = w_g1 & S_ACK_I;
    assign M0_ERR_O = w_g0 & w_timeout;
    assign M1_ERR_O = w_g1 & w_timeout;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;   // master 0 wins the first tie
            r_cnt        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_req0 && w_req1) begin
                        if (r_last_grant) begin
                            r_state      <= GRANT0;
                            r_last_grant <= 1'b0;
                        end else begin
                            r_state      <= GRANT1;
                            r_last_grant <= 1'b1;
                        end
                    end else if (w_req0) begin
                        r_state      <= GRANT0;
                        r_last_grant <= 1'b0;
                    end else if (w_req1) begin
                        r_state      <= GRANT1;
                        r_last_grant <= 1'b1;
                    end
                end

                GRANT0, GRANT1: begin
                    // last_grant is left alone on exit, so after a timeout the
                    // other master wins the next tie.
                    if (!w_cyc_sel || w_timeout) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (w_stb_sel && !S_ACK_I) begin
                        r_cnt   <= r_cnt + CW'(1);
                    end else begin
                        r_cnt   <= '0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
